// File: rtl/ec_fe6_addsub_serial.sv
// ---------------------------------------------------------------------------
// ec_fe6_addsub_serial
//
// Serial Fp6 add/subtract responder. It accepts a packed pair {b, a} of Fp6
// elements (six Fp coefficients each). It then produces (a+b) mod P or
// (a-b) mod P one coefficient per cycle through a single shared modular
// datapath. The request ctl/err sideband is echoed with the result.
//
// Optional feature (compile-time macro FE6_ADDSUB_RANGE_CHK_EN):
//   When defined, every operand coefficient is compared against P while it
//   is processed. Any coefficient >= P sets a sticky flag that is ORed into
//   o_err. When undefined, no comparators are built and o_err is the
//   captured i_err.
//
// Parameters:
//   DAT_BITS  width of one Fp coefficient
//   P         field modulus (BLS12-381 base-field prime by default)
//   CTL_BITS  width of the pass-through ctl sideband
//   SUB       0: compute a+b, 1: compute a-b
//
// Ports:
//   i_clk   clock, rising edge
//   i_rst   synchronous reset, active low
//   i_dat   request {b, a}; coefficient k of a at [k*DAT_BITS +: DAT_BITS]
//   i_val   request valid
//   i_rdy   request ready (high only while idle)
//   i_ctl   request sideband
//   i_err   request error flag
//   o_dat   result; coefficient k at [k*DAT_BITS +: DAT_BITS]
//   o_val   result valid
//   o_rdy   downstream ready
//   o_ctl   echoed ctl
//   o_err   echoed err (optionally ORed with the range-check flag)
// ---------------------------------------------------------------------------
module ec_fe6_addsub_serial #(
   parameter int                  DAT_BITS = 381,
   parameter logic [DAT_BITS-1:0] P        = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab,
   parameter int                  CTL_BITS = 12,
   parameter bit                  SUB      = 1'b0
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [12*DAT_BITS-1:0]  i_dat,
   input  logic                    i_val,
   output logic                    i_rdy,
   input  logic [CTL_BITS-1:0]     i_ctl,
   input  logic                    i_err,
   output logic [6*DAT_BITS-1:0]   o_dat,
   output logic                    o_val,
   input  logic                    o_rdy,
   output logic [CTL_BITS-1:0]     o_ctl,
   output logic                    o_err
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                 state_reg, state_next;
   logic [2:0]             cnt_reg, cnt_next;
   logic                   o_val_reg, o_val_next;
   logic [6*DAT_BITS-1:0]  a_reg, b_reg;
   logic [CTL_BITS-1:0]    ctl_reg, o_ctl_reg;
   logic                   err_reg, o_err_reg;

   logic                   hs;
   logic                   last;
   logic [DAT_BITS-1:0]    a_coef [6];
   logic [DAT_BITS-1:0]    b_coef [6];
   logic [DAT_BITS-1:0]    a_k, b_k, r_k;
   logic                   oor_k;

   assign i_rdy = (state_reg == IDLE);
   assign hs    = i_val && i_rdy;
   assign last  = (state_reg == CALC) && (cnt_reg == 3'd5);

   // ---------------- control FSM ----------------
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 3'd0;
         o_val_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         o_val_reg <= o_val_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      o_val_next = o_val_reg;
      case (state_reg)
         IDLE: begin
            if (hs) begin
               state_next = CALC;
               cnt_next   = 3'd0;
            end
         end
         CALC: begin
            if (cnt_reg == 3'd5) begin
               state_next = DONE;
               o_val_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + 3'd1;
            end
         end
         DONE: begin
            if (o_val_reg && o_rdy) begin
               state_next = IDLE;
               o_val_next = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- request capture ----------------
   // Operands are only meaningful after a handshake, so they carry no reset.
   always_ff @(posedge i_clk) begin
      if (hs) begin
         a_reg   <= i_dat[0 +: 6*DAT_BITS];
         b_reg   <= i_dat[6*DAT_BITS +: 6*DAT_BITS];
         ctl_reg <= i_ctl;
         err_reg <= i_err;
      end
   end

   // ---------------- shared coefficient datapath ----------------
   for (genvar gi = 0; gi < 6; gi++) begin : g_split
      assign a_coef[gi] = a_reg[gi*DAT_BITS +: DAT_BITS];
      assign b_coef[gi] = b_reg[gi*DAT_BITS +: DAT_BITS];
   end

   assign a_k = a_coef[cnt_reg];
   assign b_k = b_coef[cnt_reg];

   // One extra bit keeps the carry of a+b (or the borrow of a-b) visible.
   if (SUB == 1'b0) begin : g_add
      logic [DAT_BITS:0] sum_w;
      assign sum_w = {1'b0, a_k} + {1'b0, b_k};
      assign r_k   = (sum_w >= {1'b0, P}) ? DAT_BITS'(sum_w - {1'b0, P})
                                          : DAT_BITS'(sum_w);
   end else begin : g_sub
      logic [DAT_BITS:0] diff_w;
      assign diff_w = {1'b0, a_k} - {1'b0, b_k};
      assign r_k    = (a_k >= b_k) ? DAT_BITS'(diff_w)
                                   : DAT_BITS'(diff_w + {1'b0, P});
   end

   // Each result coefficient has its own register; only the slot selected
   // by cnt is written in a given CALC cycle.
   for (genvar gi = 0; gi < 6; gi++) begin : g_res
      logic [DAT_BITS-1:0] coef_reg;
      always_ff @(posedge i_clk) begin
         if (!i_rst)
            coef_reg <= '0;
         else if ((state_reg == CALC) && (cnt_reg == 3'(gi)))
            coef_reg <= r_k;
      end
      assign o_dat[gi*DAT_BITS +: DAT_BITS] = coef_reg;
   end

   // ---------------- optional operand range check ----------------
`ifdef FE6_ADDSUB_RANGE_CHK_EN
   logic range_flag_reg;

   assign oor_k = (state_reg == CALC) && ((a_k >= P) || (b_k >= P));

   always_ff @(posedge i_clk) begin
      if (!i_rst)
         range_flag_reg <= 1'b0;
      else if (hs)
         range_flag_reg <= 1'b0;
      else if (oor_k)
         range_flag_reg <= 1'b1;
   end
`else
   logic range_flag_reg;

   assign oor_k          = 1'b0;
   assign range_flag_reg = 1'b0;
`endif

   // ---------------- result sideband ----------------
   // The last coefficient's own range check is folded in directly, since
   // the sticky flag would only see it one cycle later.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         o_ctl_reg <= '0;
         o_err_reg <= 1'b0;
      end else if (last) begin
         o_ctl_reg <= ctl_reg;
         o_err_reg <= err_reg | range_flag_reg | oor_k;
      end
   end

   assign o_val = o_val_reg;
   assign o_ctl = o_ctl_reg;
   assign o_err = o_err_reg;

endmodule

// File: tb/tb_ec_fe6_addsub_serial.sv
// ---------------------------------------------------------------------------
// tb_ec_fe6_addsub_serial
//
// Two DUT instances (add and sub) with DAT_BITS=4, P=13. Requests are driven
// from a vector table and hand-written sequences. Expected results are pushed
// to a scoreboard queue at each handshake and compared when the DUT
// presents them.
// ---------------------------------------------------------------------------
module tb_ec_fe6_addsub_serial;

   localparam int         DW = 4;
   localparam logic [3:0] PM = 4'd13;
   localparam int         CW = 12;

`ifdef FE6_ADDSUB_RANGE_CHK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic [12*DW-1:0] i_dat [2];
   logic             i_val [2];
   logic             i_rdy [2];
   logic [CW-1:0]    i_ctl [2];
   logic             i_err [2];
   logic [6*DW-1:0]  o_dat [2];
   logic             o_val [2];
   logic             o_rdy [2];
   logic [CW-1:0]    o_ctl [2];
   logic             o_err [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      ec_fe6_addsub_serial #(
         .DAT_BITS (DW),
         .P        (PM),
         .CTL_BITS (CW),
         .SUB      (gi == 1)
      ) u_dut (
         .i_clk (clk),
         .i_rst (rst_n),
         .i_dat (i_dat[gi]),
         .i_val (i_val[gi]),
         .i_rdy (i_rdy[gi]),
         .i_ctl (i_ctl[gi]),
         .i_err (i_err[gi]),
         .o_dat (o_dat[gi]),
         .o_val (o_val[gi]),
         .o_rdy (o_rdy[gi]),
         .o_ctl (o_ctl[gi]),
         .o_err (o_err[gi])
      );
   end

   int cyc    = 0;
   int errors = 0;
   int checks = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          inst;
      logic [23:0] dat;
      logic [11:0] ctl;
      logic        err;
      bit          chk_dat;
      int          hs;
   } exp_t;

   typedef struct {
      int          inst;
      logic [23:0] a;
      logic [23:0] b;
      logic [11:0] ctl;
      logic        err;
      logic [23:0] exp_dat;
      logic        exp_err;
      bit          chk_dat;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [23:0] pack6(input int c0, input int c1, input int c2,
                                         input int c3, input int c4, input int c5);
      return {4'(c5), 4'(c4), 4'(c3), 4'(c2), 4'(c1), 4'(c0)};
   endfunction

   // Reference model: plain integer modular arithmetic per coefficient.
   function automatic logic [23:0] model(input int sub, input logic [23:0] a, input logic [23:0] b);
      logic [23:0] r;
      int x, y, z;
      r = '0;
      for (int k = 0; k < 6; k++) begin
         x = int'(a[k*4 +: 4]);
         y = int'(b[k*4 +: 4]);
         z = (sub != 0) ? (x - y + 13) % 13 : (x + y) % 13;
         r[k*4 +: 4] = 4'(z);
      end
      return r;
   endfunction

   // Called just after a rising edge. Returns the cycle number of the
   // handshake edge, or -1 on timeout.
   task automatic send(input int j, input logic [23:0] a, input logic [23:0] b,
                       input logic [11:0] ctl, input logic err,
                       input logic [23:0] ed, input logic ee, input bit cd,
                       input bit keep, output int hs);
      bit got;
      got = 1'b0;
      hs  = -1;
      i_dat[j] = {b, a};
      i_ctl[j] = ctl;
      i_err[j] = err;
      i_val[j] = 1'b1;
      for (int t = 0; t < 50 && !got; t++) begin
         @(negedge clk);
         if (i_rdy[j]) begin
            got = 1'b1;
            hs  = cyc + 1;
            sb.push_back('{j, ed, ctl, ee, cd, cyc + 1});
         end
      end
      if (!got) begin
         chk("handshake_timeout", 64'd0, 64'd1);
         i_val[j] = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         if (!keep) i_val[j] = 1'b0;
      end
   endtask

   task automatic wait_idle(input string name);
      bit done;
      done = 1'b0;
      for (int t = 0; t < 80 && !done; t++) begin
         @(negedge clk);
         if (sb.size() == 0) done = 1'b1;
      end
      if (!done) begin
         chk(name, 64'(sb.size()), 64'd0);
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: latency on the rising o_val, payload on each output handshake.
   logic pv [2];
   always @(negedge clk) begin
      exp_t e;
      for (int j = 0; j < 2; j++) begin
         if (rst_n && o_val[j] && !pv[j] && sb.size() > 0)
            chk("latency", 64'(cyc - sb[0].hs), 64'd6);
         if (rst_n && o_val[j] && o_rdy[j]) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("out_inst", 64'(j), 64'(e.inst));
               if (e.chk_dat) chk("o_dat", 64'(o_dat[j]), 64'(e.dat));
               chk("o_ctl", 64'(o_ctl[j]), 64'(e.ctl));
               chk("o_err", 64'(o_err[j]), 64'(e.err));
               $display("out inst=%0d dat=%06h ctl=%03h err=%0b", j, o_dat[j], o_ctl[j], o_err[j]);
            end
         end
         pv[j] <= o_val[j];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          hs0, hs1, hs2;
      bit          bad;
      logic [23:0] ra, rb, bp_exp;

      rst_n = 1'b0;
      for (int j = 0; j < 2; j++) begin
         i_dat[j] = '0;
         i_val[j] = 1'b0;
         i_ctl[j] = '0;
         i_err[j] = 1'b0;
         o_rdy[j] = 1'b1;
      end

      vecs[0] = '{0, pack6(1,2,3,4,5,6),    pack6(12,11,10,0,0,7), 12'h5A5, 1'b0, pack6(0,0,0,4,5,0),    1'b0, 1'b1};
      vecs[1] = '{1, pack6(0,5,12,3,0,7),   pack6(1,5,0,4,12,2),   12'h0C3, 1'b0, pack6(12,0,12,12,1,5), 1'b0, 1'b1};
      vecs[2] = '{0, pack6(0,0,14,0,0,0),   pack6(0,0,0,0,0,0),    12'h111, 1'b0, pack6(0,0,0,0,0,0),    RC,   1'b0};
      vecs[3] = '{0, pack6(12,12,0,6,1,9),  pack6(12,1,0,7,11,4),  12'hFFF, 1'b1, pack6(11,0,0,0,12,0),  1'b1, 1'b1};
      vecs[4] = '{1, pack6(2,12,4,0,9,1),   pack6(15,0,4,12,3,1),  12'h800, 1'b0, pack6(0,0,0,0,0,0),    RC,   1'b0};
      vecs[5] = '{1, pack6(12,0,6,11,1,3),  pack6(0,12,7,11,2,3),  12'h001, 1'b1, pack6(12,1,12,0,12,0), 1'b1, 1'b1};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
         chk("rst_o_val", 64'(o_val[j]), 64'd0);
         chk("rst_o_dat", 64'(o_dat[j]), 64'd0);
         chk("rst_o_ctl", 64'(o_ctl[j]), 64'd0);
         chk("rst_o_err", 64'(o_err[j]), 64'd0);
         chk("rst_i_rdy", 64'(i_rdy[j]), 64'd1);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table-driven vectors
      for (int i = 0; i < 6; i++) begin
         $display("vec %0d inst=%0d a=%06h b=%06h ctl=%03h err=%0b", i, vecs[i].inst,
                  vecs[i].a, vecs[i].b, vecs[i].ctl, vecs[i].err);
         send(vecs[i].inst, vecs[i].a, vecs[i].b, vecs[i].ctl, vecs[i].err,
              vecs[i].exp_dat, vecs[i].exp_err, vecs[i].chk_dat, 1'b0, hs0);
         wait_idle("vec_drain");
         chk("post_o_val", 64'(o_val[vecs[i].inst]), 64'd0);
         chk("post_i_rdy", 64'(i_rdy[vecs[i].inst]), 64'd1);
      end

      // Backpressure: hold o_rdy low for 20 cycles after o_val rises
      o_rdy[0] = 1'b0;
      bp_exp   = pack6(7,0,12,3,9,1);
      send(0, pack6(3,6,5,1,4,0), pack6(4,7,7,2,5,1), 12'h3C3, 1'b0,
           bp_exp, 1'b0, 1'b1, 1'b0, hs0);
      bad = 1'b1;
      for (int t = 0; t < 40 && bad; t++) begin
         @(negedge clk);
         if (o_val[0]) bad = 1'b0;
      end
      chk("bp_o_val_rise", 64'(bad), 64'd0);
      for (int t = 0; t < 20; t++) begin
         if (t > 0) @(negedge clk);
         if (!o_val[0] || o_dat[0] !== bp_exp || o_ctl[0] !== 12'h3C3 || i_rdy[0])
            bad = 1'b1;
      end
      chk("bp_stable", 64'(bad), 64'd0);
      $display("backpressure held 20 cycles dat=%06h", o_dat[0]);
      @(posedge clk);
      #1;
      o_rdy[0] = 1'b1;
      wait_idle("bp_drain");
      chk("bp_o_val_fall", 64'(o_val[0]), 64'd0);
      chk("bp_i_rdy", 64'(i_rdy[0]), 64'd1);

      // Back-to-back: i_val held, three distinct requests
      begin
         int hsv [3];
         for (int i = 0; i < 3; i++) begin
            ra = pack6($urandom_range(0,12), $urandom_range(0,12), $urandom_range(0,12),
                       $urandom_range(0,12), $urandom_range(0,12), 12'(i));
            rb = pack6($urandom_range(0,12), $urandom_range(0,12), $urandom_range(0,12),
                       $urandom_range(0,12), $urandom_range(0,12), 12);
            $display("b2b %0d a=%06h b=%06h", i, ra, rb);
            send(1, ra, rb, 12'(16 + i), 1'b0, model(1, ra, rb), 1'b0, 1'b1,
                 (i < 2), hsv[i]);
         end
         chk("b2b_gap01", 64'(hsv[1] - hsv[0]), 64'd8);
         chk("b2b_gap12", 64'(hsv[2] - hsv[1]), 64'd8);
      end
      wait_idle("b2b_drain");

      // Reset in the middle of a calculation (cnt==3)
      send(0, pack6(5,5,5,5,5,5), pack6(5,5,5,5,5,5), 12'h777, 1'b0,
           pack6(10,10,10,10,10,10), 1'b0, 1'b1, 1'b0, hs0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      sb.delete();
      chk("midrst_o_val", 64'(o_val[0]), 64'd0);
      chk("midrst_i_rdy", 64'(i_rdy[0]), 64'd1);
      $display("reset applied mid-calculation");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(0, pack6(1,1,1,1,1,1), 24'd0, 12'h0AA, 1'b0,
           pack6(1,1,1,1,1,1), 1'b0, 1'b1, 1'b0, hs0);
      wait_idle("midrst_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ec_fe6_addsub_serial.md
Name: ec_fe6_addsub_serial

Overview:
- Responder-side engine that services Fp6 add/subtract requests on the stream interface used by the Fp12 arithmetic block.
- Accepts a packed pair {b, a} of Fp6 elements and returns (a+b) mod P or (a−b) mod P with ctl echoed unchanged.
- Processes the six Fp coefficients serially through one shared modular add/sub datapath, trading throughput for area.
- Sits behind a resource_share arbiter, or is connected directly to the o_add_fe6_if / o_sub_fe6_if ports.

Parameters:
- DAT_BITS, 381: width of one Fp coefficient.
- P, BLS12-381 base-field prime: modulus, DAT_BITS wide.
- CTL_BITS, 12: width of the sideband ctl field, passed through unmodified.
- SUB, 0: 0 = instance computes a+b; 1 = instance computes a−b.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous reset, active-low.
- i_dat  in  12*DAT_BITS  request; a = [0 +: 6*DAT_BITS], b = [6*DAT_BITS +: 6*DAT_BITS]; coefficient k of each at [k*DAT_BITS +: DAT_BITS].
- i_val  in  1  request valid.
- i_rdy  out  1  request ready.
- i_ctl  in  CTL_BITS  request sideband.
- i_err  in  1  request error flag.
- o_dat  out  6*DAT_BITS  result; coefficient k at [k*DAT_BITS +: DAT_BITS].
- o_val  out  1  result valid.
- o_rdy  in  1  downstream ready.
- o_ctl  out  CTL_BITS  echoed i_ctl.
- o_err  out  1  echoed i_err (see Optional Feature).

Behaviour:
- Reset (i_rst==0 at a clock edge):
  - state=IDLE, cnt=0, o_val=0, o_dat=0, o_ctl=0, o_err=0.
  - Any in-flight request is discarded; no partial result is ever presented.
- i_rdy = (state==IDLE), combinational from state only. It has no path from i_val or o_rdy.
- IDLE:
  - On i_val && i_rdy, capture a, b, i_ctl and i_err into holding registers.
  - Set cnt=0 and go to CALC.
- CALC: one coefficient per cycle, k = cnt.
  - Add (SUB=0): s = a[k] + b[k] with DAT_BITS+1-bit intermediate; r = (s >= P) ? s − P : s.
  - Sub (SUB=1): r = (a[k] >= b[k]) ? a[k] − b[k] : a[k] − b[k] + P, computed modulo 2^(DAT_BITS+1) and truncated to DAT_BITS.
  - Write r to o_dat[k*DAT_BITS +: DAT_BITS].
  - When cnt==5: set o_val=1, copy captured ctl/err to o_ctl/o_err, go to DONE. Otherwise cnt++.
- DONE:
  - Hold o_dat, o_ctl, o_err and o_val stable while o_rdy==0.
  - On o_val && o_rdy: o_val=0, go to IDLE.
- Latency: request handshake at edge T0 → o_val high after edge T6 (6 cycles).
- Throughput: one request per 8 cycles, with o_rdy held high.
- Preconditions: operands are < P. Results for out-of-range inputs are undefined unless the Optional Feature is enabled.
- o_dat contents are don't-care while o_val==0. Partially written coefficients may be visible during CALC.
- i_val asserted outside IDLE is ignored; the source must hold it.
- i_dat, i_ctl and i_err are sampled only at the handshake; later changes have no effect.

Optional Feature:
- Macro: FE6_ADDSUB_RANGE_CHK_EN.
- Defined:
  - During CALC, each a[k] and b[k] is compared against P.
  - If any operand is >= P, a sticky flag is set; the result is still computed.
  - o_err = captured i_err OR flag.
  - The flag clears on entry to CALC.
- Undefined:
  - No comparators are built.
  - o_err = captured i_err.

Test Plan:
Bench instance: DAT_BITS=4, P=13.
- Add, SUB=0: a coefficients (1,2,3,4,5,6), b=(12,11,10,0,0,7), ctl=0x5A5, o_rdy=1 → o_dat=(0,0,0,4,5,0), o_ctl=0x5A5, o_val high exactly 6 cycles after the handshake, held for 1 cycle.
- Sub, SUB=1: a=(0,5,12,3,0,7), b=(1,5,0,4,12,2) → o_dat=(12,0,12,12,1,5), o_err=0.
- Backpressure: o_rdy=0 for 20 cycles after o_val rises → o_dat/o_ctl stable and i_rdy=0 throughout; o_rdy=1 → o_val falls next edge and i_rdy=1.
- Back-to-back: i_val held high with 3 distinct requests, o_rdy=1 → 3 correct results in order, handshakes 8 cycles apart, no request lost or duplicated.
- Reset mid-operation: assert i_rst=0 at cnt==3 → after that edge o_val=0, i_rdy=1; the next request (a=(1,1,1,1,1,1), b=0) returns (1,1,1,1,1,1).
- Range check, macro defined: a[2]=14, i_err=0 → o_err=1. Same stimulus with the macro undefined → o_err=0. i_err=1 with in-range operands → o_err=1 in both builds.
